// File: rtl/gen_sweep_pkg.sv
// Shared constants for the generator sweep sequencer: register map, CTRL bits, state encoding.
package gen_sweep_pkg;

  localparam int unsigned PHASE_W_DEF = 48;
  localparam int unsigned ATTN_W_DEF  = 18;
  localparam int unsigned DWELL_W_DEF = 32;
  localparam int unsigned NSTEP_W_DEF = 16;
  localparam int unsigned RAMP_SH_DEF = 8;

  localparam int unsigned CFG_ADDR_W = 3;
  localparam int unsigned CFG_DATA_W = 32;

  localparam logic [2:0] CFG_START_H = 3'd0;
  localparam logic [2:0] CFG_START_L = 3'd1;
  localparam logic [2:0] CFG_STEP_H  = 3'd2;
  localparam logic [2:0] CFG_STEP_L  = 3'd3;
  localparam logic [2:0] CFG_DWELL   = 3'd4;
  localparam logic [2:0] CFG_NSTEPS  = 3'd5;
  localparam logic [2:0] CFG_ATTN    = 3'd6;
  localparam logic [2:0] CFG_CTRL    = 3'd7;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_STOP  = 1;
  localparam int unsigned CTRL_LOOP  = 2;
  localparam int unsigned CTRL_DIR   = 3;

  // STEP is the last cycle of every point; DWELL covers the cycles before it.
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DWELL   = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_RAMP_UP = 3'd3;
  localparam logic [2:0] ST_RAMP_DN = 3'd4;

endpackage

// File: rtl/gen_attn_ramp.sv
// Gain ramp: moves level toward target by a fixed step every 2^RAMP_SH cycles, saturating at target.
// Only built when GEN_SWEEP_RAMP_EN is defined.
`ifdef GEN_SWEEP_RAMP_EN
module gen_attn_ramp
  import gen_sweep_pkg::*;
#(
  parameter int unsigned ATTN_W  = ATTN_W_DEF,
  parameter int unsigned RAMP_SH = RAMP_SH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic                     run,
  input  logic signed [ATTN_W-1:0] init_val,
  input  logic signed [ATTN_W-1:0] target,
  output logic signed [ATTN_W-1:0] level,
  output logic                     settled_c
);

  localparam logic signed [ATTN_W:0] RAMP_STEP = (ATTN_W+1)'(1) << (ATTN_W - 11);

  logic [RAMP_SH-1:0]       tick_q;
  logic signed [ATTN_W:0]   ext_lvl, ext_tgt, up, dn;
  logic signed [ATTN_W-1:0] nxt;

  // One guard bit keeps the +/- step from overflowing before the saturation compare.
  always_comb begin
    ext_lvl = {level[ATTN_W-1], level};
    ext_tgt = {target[ATTN_W-1], target};
    up      = ext_lvl + RAMP_STEP;
    dn      = ext_lvl - RAMP_STEP;
    nxt     = level;
    if (ext_lvl < ext_tgt) begin
      nxt = (up >= ext_tgt) ? target : ATTN_W'(up);
    end else if (ext_lvl > ext_tgt) begin
      nxt = (dn <= ext_tgt) ? target : ATTN_W'(dn);
    end
  end

  assign settled_c = (level == target);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      level  <= '0;
    end else if (init) begin
      tick_q <= '0;
      level  <= init_val;
    end else if (run) begin
      tick_q <= tick_q + RAMP_SH'(1);
      if (&tick_q) level <= nxt;
    end
  end

endmodule
`endif

// File: rtl/gen_sweep_ctrl.sv
// Frequency-sweep / attenuation sequencer feeding DDS phase increment and generator gain.
// Optional gain ramping on start/stop is enabled by defining GEN_SWEEP_RAMP_EN.
module gen_sweep_ctrl
  import gen_sweep_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned ATTN_W  = ATTN_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned NSTEP_W = NSTEP_W_DEF,
  parameter int unsigned RAMP_SH = RAMP_SH_DEF
) (
  input  logic                     adc_clk,
  input  logic                     reset,
  input  logic                     cfg_wr,
  input  logic [CFG_ADDR_W-1:0]    cfg_addr,
  input  logic [CFG_DATA_W-1:0]    cfg_data,
  output logic [PHASE_W-1:0]       gen_phase_inc,
  output logic signed [ATTN_W-1:0] gen_attn,
  output logic                     sweep_busy,
  output logic                     sweep_done,
  output logic [NSTEP_W-1:0]       step_idx
);

  logic [STATE_W-1:0]       state_q, state_d;
  logic [PHASE_W-1:0]       start_sh_q, start_sh_d, step_sh_q, step_sh_d;
  logic [DWELL_W-1:0]       dwell_sh_q, dwell_sh_d;
  logic [NSTEP_W-1:0]       nsteps_sh_q, nsteps_sh_d;
  logic signed [ATTN_W-1:0] attn_reg_q, attn_reg_d;
  logic                     loop_sh_q, loop_sh_d, dir_sh_q, dir_sh_d;
  logic [PHASE_W-1:0]       step_a_q, step_a_d;
  logic [NSTEP_W-1:0]       nsteps_a_q, nsteps_a_d;
  logic [DWELL_W-1:0]       dwell_a_q, dwell_a_d, dwell_cnt_q, dwell_cnt_d;
  logic                     loop_a_q, loop_a_d, dir_a_q, dir_a_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic signed [ATTN_W-1:0] attn_q, attn_d;
  logic [NSTEP_W-1:0]       idx_q, idx_d;
  logic                     busy_q, busy_d, done_q, done_d, muted_q, muted_d;

  logic                     start_w, stop_w, load_pt;
  logic [DWELL_W-1:0]       dwell_eff;
  logic [STATE_W-1:0]       first_state;

  assign start_w     = cfg_wr && (cfg_addr == CFG_CTRL) && cfg_data[CTRL_START];
  assign stop_w      = cfg_wr && (cfg_addr == CFG_CTRL) && cfg_data[CTRL_STOP];
  assign dwell_eff   = (dwell_sh_q == '0) ? DWELL_W'(1) : dwell_sh_q;
  assign first_state = (dwell_eff == DWELL_W'(1)) ? ST_STEP : ST_DWELL;

`ifdef GEN_SWEEP_RAMP_EN
  logic                     ramp_init, ramp_run, ramp_settled_c;
  logic signed [ATTN_W-1:0] ramp_init_val, ramp_target, ramp_level;

  assign ramp_run    = ((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DN)) && !ramp_init;
  assign ramp_target = (state_q == ST_RAMP_DN) ? '0 : attn_reg_q;

  gen_attn_ramp #(
    .ATTN_W  (ATTN_W),
    .RAMP_SH (RAMP_SH)
  ) u_ramp (
    .clk       (adc_clk),
    .reset     (reset),
    .init      (ramp_init),
    .run       (ramp_run),
    .init_val  (ramp_init_val),
    .target    (ramp_target),
    .level     (ramp_level),
    .settled_c (ramp_settled_c)
  );
`endif

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_sh_q  <= '0;
      step_sh_q   <= '0;
      dwell_sh_q  <= '0;
      nsteps_sh_q <= '0;
      attn_reg_q  <= '0;
      loop_sh_q   <= 1'b0;
      dir_sh_q    <= 1'b0;
      step_a_q    <= '0;
      nsteps_a_q  <= '0;
      dwell_a_q   <= '0;
      dwell_cnt_q <= '0;
      loop_a_q    <= 1'b0;
      dir_a_q     <= 1'b0;
      phase_q     <= '0;
      attn_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      muted_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      start_sh_q  <= start_sh_d;
      step_sh_q   <= step_sh_d;
      dwell_sh_q  <= dwell_sh_d;
      nsteps_sh_q <= nsteps_sh_d;
      attn_reg_q  <= attn_reg_d;
      loop_sh_q   <= loop_sh_d;
      dir_sh_q    <= dir_sh_d;
      step_a_q    <= step_a_d;
      nsteps_a_q  <= nsteps_a_d;
      dwell_a_q   <= dwell_a_d;
      dwell_cnt_q <= dwell_cnt_d;
      loop_a_q    <= loop_a_d;
      dir_a_q     <= dir_a_d;
      phase_q     <= phase_d;
      attn_q      <= attn_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      muted_q     <= muted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_sh_d  = start_sh_q;
    step_sh_d   = step_sh_q;
    dwell_sh_d  = dwell_sh_q;
    nsteps_sh_d = nsteps_sh_q;
    attn_reg_d  = attn_reg_q;
    loop_sh_d   = loop_sh_q;
    dir_sh_d    = dir_sh_q;
    step_a_d    = step_a_q;
    nsteps_a_d  = nsteps_a_q;
    dwell_a_d   = dwell_a_q;
    dwell_cnt_d = dwell_cnt_q;
    loop_a_d    = loop_a_q;
    dir_a_d     = dir_a_q;
    phase_d     = phase_q;
    attn_d      = attn_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    muted_d     = muted_q;
    load_pt     = 1'b0;
`ifdef GEN_SWEEP_RAMP_EN
    ramp_init     = 1'b0;
    ramp_init_val = '0;
`endif

    // Config writes land in shadow registers; the sweep only sees them at START or loop reload.
    if (cfg_wr) begin
      case (cfg_addr)
        CFG_START_H: start_sh_d[PHASE_W-1:16] = cfg_data[PHASE_W-17:0];
        CFG_START_L: start_sh_d[15:0]         = cfg_data[15:0];
        CFG_STEP_H:  step_sh_d[PHASE_W-1:16]  = cfg_data[PHASE_W-17:0];
        CFG_STEP_L:  step_sh_d[15:0]          = cfg_data[15:0];
        CFG_DWELL:   dwell_sh_d               = cfg_data[DWELL_W-1:0];
        CFG_NSTEPS:  nsteps_sh_d              = cfg_data[NSTEP_W-1:0];
        CFG_ATTN: begin
          attn_reg_d = cfg_data[ATTN_W-1:0];
          if (!muted_q) attn_d = cfg_data[ATTN_W-1:0];
        end
        CFG_CTRL: begin
          loop_sh_d = cfg_data[CTRL_LOOP];
          dir_sh_d  = cfg_data[CTRL_DIR];
        end
        default: ;
      endcase
    end

    if (stop_w) begin
`ifdef GEN_SWEEP_RAMP_EN
      if (state_q != ST_IDLE) begin
        state_d       = ST_RAMP_DN;
        ramp_init     = 1'b1;
        ramp_init_val = attn_q;
      end else begin
        attn_d  = '0;
        muted_d = 1'b1;
      end
`else
      state_d = ST_IDLE;
      attn_d  = '0;
      muted_d = 1'b1;
`endif
    end else if (start_w) begin
      load_pt  = 1'b1;
      loop_a_d = loop_sh_d;
      dir_a_d  = dir_sh_d;
      muted_d  = 1'b0;
      attn_d   = attn_reg_q;
    end else begin
      case (state_q)
        ST_DWELL: begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          if (dwell_cnt_q <= DWELL_W'(2)) state_d = ST_STEP;
        end
        ST_STEP: begin
          if (idx_q == nsteps_a_q) begin
            if (loop_a_q) begin
              load_pt = 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            phase_d     = dir_a_q ? (phase_q - step_a_q) : (phase_q + step_a_q);
            idx_d       = idx_q + NSTEP_W'(1);
            dwell_cnt_d = dwell_a_q;
            state_d     = (dwell_a_q == DWELL_W'(1)) ? ST_STEP : ST_DWELL;
          end
        end
`ifdef GEN_SWEEP_RAMP_EN
        ST_RAMP_UP: begin
          attn_d = ramp_level;
          if (ramp_settled_c) begin
            dwell_cnt_d = dwell_a_q;
            state_d     = (dwell_a_q == DWELL_W'(1)) ? ST_STEP : ST_DWELL;
          end
        end
        ST_RAMP_DN: begin
          attn_d = ramp_level;
          if (ramp_settled_c) begin
            state_d = ST_IDLE;
            muted_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end

    // Load the first point of a sweep from the shadow registers.
    if (load_pt) begin
      phase_d     = start_sh_q;
      idx_d       = '0;
      step_a_d    = step_sh_q;
      nsteps_a_d  = nsteps_sh_q;
      dwell_a_d   = dwell_eff;
      dwell_cnt_d = dwell_eff;
      state_d     = first_state;
    end

`ifdef GEN_SWEEP_RAMP_EN
    if (start_w && !stop_w) begin
      state_d       = ST_RAMP_UP;
      attn_d        = '0;
      ramp_init     = 1'b1;
      ramp_init_val = '0;
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  assign gen_phase_inc = phase_q;
  assign gen_attn      = attn_q;
  assign sweep_busy    = busy_q;
  assign sweep_done    = done_q;
  assign step_idx      = idx_q;

endmodule
